countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable mm:ss down-counter for the clock design, the count-down counterpart to the up-counting minute/second chain.
- Counts down one second per `tick` from a BCD preset and stops at 00:00.
- Issues a one-cycle `expired` pulse at 00:00.
- Outputs the same four-digit BCD format as the time-of-day counters, so the display path can show either source unchanged.

Parameters:
- MAX_MIN_TENS, 5, highest legal minute-tens digit; the preset range is 00:00 to (MAX_MIN_TENS)9:59.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- tick  input  1  one-cycle 1 Hz enable pulse, synchronous to clk
- load  input  1  capture preset digits this cycle
- ld_min_tens  input  4  preset minute tens (BCD)
- ld_min_ones  input  4  preset minute ones (BCD)
- ld_sec_tens  input  4  preset second tens (BCD)
- ld_sec_ones  input  4  preset second ones (BCD)
- start  input  1  start or resume counting
- pause  input  1  suspend counting
- min_tens  output  4  current minute tens (BCD)
- min_ones  output  4  current minute ones (BCD)
- sec_tens  output  4  current second tens (BCD)
- sec_ones  output  4  current second ones (BCD)
- running  output  1  high while in RUN
- sec_borrow  output  1  one-cycle pulse when seconds wrap 00->59
- expired  output  1  one-cycle pulse when the count reaches 00:00

Behaviour:
- Reset (async): all digits 0, state IDLE, running=0, sec_borrow=0, expired=0.
- Storage and outputs:
  - Digits are held directly as BCD registers; no binary count, no divide/modulo.
  - All outputs are registered.
- FSM states: IDLE, RUN, PAUSED, DONE. running = (state==RUN).
- Priority each cycle: load > pause/start > tick.
- load (any state):
  - Digits take the preset next cycle; state goes to IDLE; pulses are 0.
  - Clamping is per digit: min_tens > MAX_MIN_TENS -> MAX_MIN_TENS; sec_tens > 5 -> 5; any ones digit > 9 -> 9.
- start:
  - IDLE or PAUSED with nonzero value -> RUN.
  - Value 00:00 -> start is ignored and the state is unchanged.
  - start in RUN or DONE is ignored.
- pause:
  - RUN -> PAUSED.
  - If pause and start are both high: in RUN, pause wins; in PAUSED, start wins (resume).
- tick in RUN with no load/pause that cycle decrements by one second:
  - sec_ones > 0: sec_ones - 1.
  - Else sec_tens > 0: sec_ones = 9, sec_tens - 1.
  - Else (seconds 00), with minutes > 0: seconds = 59, minutes decrement with the same BCD borrow rule, sec_borrow = 1 for one cycle.
- Terminal count:
  - When a decrement produces 00:00, the same clock edge sets state DONE, running=0, and expired=1 for exactly one cycle.
  - The 01:00 -> 00:59 step does not expire.
- Tick gating:
  - A tick in the same cycle as a start edge is not applied; the first decrement occurs on the next tick.
  - Ticks in IDLE, PAUSED and DONE are ignored.
- DONE: digits hold 00:00; only load or reset leave this state.
- Latency: output digits change one clk after the qualifying tick. expired and sec_borrow rise on that same edge and clear on the following edge.
- Pulse width: sec_borrow and expired never stay high longer than one cycle, even with back-to-back ticks.
- Reset mid-count: immediate return to the reset values; no expired pulse.

Test Plan:
1. Reset, load 01:02, start, 3 ticks -> 01:01, 01:00, then 00:59 with sec_borrow=1 for one cycle; expired stays 0.
2. Load 00:02, start, 2 ticks -> 00:01, then 00:00 with expired=1 for one cycle, running=0, state DONE; further ticks and start leave 00:00.
3. Load 00:10, start, 1 tick, pause, 3 ticks -> holds 00:09; start+pause together in PAUSED -> resumes; next tick -> 00:08.
4. Load digits F,F,F,F -> outputs 5,9,5,9 (59:59); start with 00:00 loaded -> running stays 0, no expired.
5. Load 00:05, start and tick in the same cycle -> value stays 00:05; next tick -> 00:04. load asserted during RUN with a tick -> preset taken, state IDLE.
6. Load 10:00, start, assert reset mid-count -> all digits 0, running=0, no expired or sec_borrow pulse; the counter stays idle after reset release.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable mm:ss BCD down-counter: one second per tick, stops at 00:00 with a one-cycle expired pulse.
// Digits are kept directly in BCD so the display path can share the time-of-day format.
module countdown_timer #(
    parameter int unsigned MAX_MIN_TENS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] ld_min_tens,
    input  logic [3:0] ld_min_ones,
    input  logic [3:0] ld_sec_tens,
    input  logic [3:0] ld_sec_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       sec_borrow,
    output logic       expired
);

    localparam int unsigned DW = 4;
    localparam logic [DW-1:0] MT_MAX = DW'(MAX_MIN_TENS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] min_tens_nxt, min_ones_nxt, sec_tens_nxt, sec_ones_nxt;
    logic          running_nxt, sec_borrow_nxt, expired_nxt;
    logic          is_zero;

    // State and all outputs registered together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            min_tens   <= '0;
            min_ones   <= '0;
            sec_tens   <= '0;
            sec_ones   <= '0;
            running    <= 1'b0;
            sec_borrow <= 1'b0;
            expired    <= 1'b0;
        end else begin
            state      <= state_nxt;
            min_tens   <= min_tens_nxt;
            min_ones   <= min_ones_nxt;
            sec_tens   <= sec_tens_nxt;
            sec_ones   <= sec_ones_nxt;
            running    <= running_nxt;
            sec_borrow <= sec_borrow_nxt;
            expired    <= expired_nxt;
        end
    end

    assign is_zero = (min_tens == '0) && (min_ones == '0) &&
                     (sec_tens == '0) && (sec_ones == '0);

    // Next state, next digits and pulses; priority load > pause/start > tick
    always_comb begin
        state_nxt      = state;
        min_tens_nxt   = min_tens;
        min_ones_nxt   = min_ones;
        sec_tens_nxt   = sec_tens;
        sec_ones_nxt   = sec_ones;
        sec_borrow_nxt = 1'b0;
        expired_nxt    = 1'b0;

        if (load) begin
            state_nxt    = IDLE;
            min_tens_nxt = (ld_min_tens > MT_MAX)   ? MT_MAX    : ld_min_tens;
            min_ones_nxt = (ld_min_ones > DW'(9))   ? DW'(9)    : ld_min_ones;
            sec_tens_nxt = (ld_sec_tens > DW'(5))   ? DW'(5)    : ld_sec_tens;
            sec_ones_nxt = (ld_sec_ones > DW'(9))   ? DW'(9)    : ld_sec_ones;
        end else begin
            case (state)
                IDLE, PAUSED: begin
                    // In PAUSED, start wins over a simultaneous pause
                    if (start && !is_zero) state_nxt = RUN;
                end
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSED;
                    end else if (tick) begin
                        if (sec_ones != '0) begin
                            sec_ones_nxt = sec_ones - DW'(1);
                        end else if (sec_tens != '0) begin
                            sec_ones_nxt = DW'(9);
                            sec_tens_nxt = sec_tens - DW'(1);
                        end else begin
                            sec_ones_nxt   = DW'(9);
                            sec_tens_nxt   = DW'(5);
                            sec_borrow_nxt = 1'b1;
                            if (min_ones != '0) begin
                                min_ones_nxt = min_ones - DW'(1);
                            end else begin
                                min_ones_nxt = DW'(9);
                                min_tens_nxt = min_tens - DW'(1);
                            end
                        end
                        // Only a step from 00:01 can land on 00:00
                        if ((min_tens == '0) && (min_ones == '0) &&
                            (sec_tens == '0) && (sec_ones == DW'(1))) begin
                            state_nxt   = DONE;
                            expired_nxt = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign running_nxt = (state_nxt == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized bench for countdown_timer: a seconds-count reference model feeds a scoreboard queue
// that a per-cycle monitor drains against the registered outputs.
module tb_countdown_timer;

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
        logic       run;
        logic       brw;
        logic       exp;
    } obs_t;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [3:0] ld_min_tens = '0, ld_min_ones = '0, ld_sec_tens = '0, ld_sec_ones = '0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, sec_borrow, expired;

    obs_t  exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    m_secs = 0;
    int    m_state = M_IDLE;
    string phase = "init";

    countdown_timer #(.MAX_MIN_TENS(5)) dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load),
        .ld_min_tens(ld_min_tens), .ld_min_ones(ld_min_ones),
        .ld_sec_tens(ld_sec_tens), .ld_sec_ones(ld_sec_ones),
        .start(start), .pause(pause),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .sec_borrow(sec_borrow), .expired(expired)
    );

    always #5 clk = ~clk;

    function automatic obs_t observed();
        obs_t o;
        o = '{mt: min_tens, mo: min_ones, st: sec_tens, so: sec_ones,
              run: running, brw: sec_borrow, exp: expired};
        return o;
    endfunction

    function automatic obs_t model_obs(input int secs, input int st, input logic b, input logic e);
        obs_t o;
        int   m;
        m     = secs / 60;
        o.mt  = 4'(m / 10);
        o.mo  = 4'(m % 10);
        o.st  = 4'((secs % 60) / 10);
        o.so  = 4'(secs % 10);
        o.run = (st == M_RUN);
        o.brw = b;
        o.exp = e;
        return o;
    endfunction

    function automatic int lim(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    // Drive one cycle of inputs and queue the outputs the model predicts after the next edge
    task automatic step(input logic t, input logic ld, input logic st, input logic ps,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
        logic brw, ex;
        @(negedge clk);
        reset = 1'b0;
        tick = t; load = ld; start = st; pause = ps;
        ld_min_tens = a; ld_min_ones = b; ld_sec_tens = c; ld_sec_ones = d;
        brw = 1'b0;
        ex  = 1'b0;
        if (ld) begin
            m_secs  = (lim(int'(a), 5) * 10 + lim(int'(b), 9)) * 60 + lim(int'(c), 5) * 10 + lim(int'(d), 9);
            m_state = M_IDLE;
        end else if ((m_state == M_IDLE || m_state == M_PAUSED) && st && m_secs != 0) begin
            m_state = M_RUN;
        end else if (m_state == M_RUN && ps) begin
            m_state = M_PAUSED;
        end else if (m_state == M_RUN && t) begin
            brw    = (m_secs % 60 == 0);
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
                m_state = M_DONE;
                ex      = 1'b1;
            end
        end
        exp_q.push_back(model_obs(m_secs, m_state, brw, ex));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic do_load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        step(1'b0, 1'b1, 1'b0, 1'b0, a, b, c, d);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset();
        obs_t got;
        @(negedge clk);
        reset = 1'b1;
        tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        #1;
        got = observed();
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL async_reset (%s): got=%h want=%h", phase, got, obs_t'('0));
        end
        m_secs  = 0;
        m_state = M_IDLE;
        exp_q.push_back(model_obs(0, M_IDLE, 1'b0, 1'b0));
    endtask

    // Monitor: outputs are registered, so compare one expectation per edge
    initial begin
        obs_t got, want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = observed();
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL outputs (%s) t=%0t: got mt%h mo%h st%h so%h run%b brw%b exp%b want mt%h mo%h st%h so%h run%b brw%b exp%b",
                             phase, $time, got.mt, got.mo, got.st, got.so, got.run, got.brw, got.exp,
                             want.mt, want.mo, want.st, want.so, want.run, want.brw, want.exp);
                end
            end
        end
    end

    initial begin
        #12;
        phase = "reset";
        do_reset();
        idle(2);

        phase = "borrow";
        do_load(4'd0, 4'd1, 4'd0, 4'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        ticks(3);
        idle(2);

        phase = "expire";
        do_load(4'd0, 4'd0, 4'd0, 4'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        ticks(2);
        ticks(2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        idle(1);

        phase = "pause";
        do_load(4'd0, 4'd0, 4'd1, 4'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        ticks(1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        ticks(3);
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        ticks(1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);

        phase = "clamp";
        do_load(4'hF, 4'hF, 4'hF, 4'hF);
        do_load(4'd0, 4'd0, 4'd0, 4'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        ticks(2);

        phase = "start_tick";
        do_load(4'd0, 4'd0, 4'd0, 4'd5);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        ticks(1);
        step(1'b1, 1'b1, 1'b0, 4'd0 != 4'd0, 4'd2, 4'd3, 4'd4, 4'd5);
        ticks(2);

        phase = "reset_mid";
        do_load(4'd1, 4'd0, 4'd0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        ticks(3);
        do_reset();
        ticks(3);

        phase = "random";
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [3:0] a, b, c, d;
            r = int'($urandom_range(0, 99));
            if (r < 6) begin
                if ($urandom_range(0, 1) == 0) begin
                    a = 4'd0; b = 4'($urandom_range(0, 1));
                    c = 4'($urandom_range(0, 1)); d = 4'($urandom_range(0, 15));
                end else begin
                    a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
                end
                step(1'($urandom), 1'b1, 1'($urandom), 1'($urandom), a, b, c, d);
            end else if (r == 6) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 99) < 60), 1'b0, ($urandom_range(0, 99) < 12),
                     ($urandom_range(0, 99) < 6), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            end
        end

        phase = "drain";
        idle(1);
        repeat (4) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
